// File: rtl/fft_mdc_pkg.sv
// Shared constants and FSM encoding for the 32-point MDC FFT sequencer.
// Pure declarations: no latency, no flow control.
package fft_mdc_pkg;
  localparam int CNT_W     = 6;
  localparam int FRAME_CYC = 32;
  localparam int PIPE_LAT  = 31;
  localparam int ST2_OFF   = 16;
  localparam int ST3_OFF   = 24;
  localparam int FRM_W     = $clog2(FRAME_CYC);
  localparam int FILL_W    = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/fft_mdc_ctrl_if.sv
// Control/status bundle between the FFT sequencer and its stream source / datapath.
// Handshake is valid/ready on the input side; outputs are pure status.
interface fft_mdc_ctrl_if;
  logic                         start;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic                         ce;
  logic [fft_mdc_pkg::CNT_W-1:0] state_code;
  logic [3:0]                   rom_16_counter;
  logic [2:0]                   rom_8_counter;
  logic [1:0]                   rom_4_counter;
  logic                         out_valid;
  logic                         out_last;
  logic                         busy;
  logic                         err;

  modport master (
    output start, in_valid, in_last,
    input  in_ready, ce, state_code, rom_16_counter, rom_8_counter, rom_4_counter,
           out_valid, out_last, busy, err
  );

  modport slave (
    input  start, in_valid, in_last,
    output in_ready, ce, state_code, rom_16_counter, rom_8_counter, rom_4_counter,
           out_valid, out_last, busy, err
  );
endinterface

// File: rtl/fft_ctrl_cnt.sv
// Enable/clear counter; at MAX it either wraps to zero or saturates.
// Single-cycle update; clear has priority over enable.
module fft_ctrl_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == MAX_V) begin
        cnt_d = SAT ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fft_mdc_ctrl.sv
// Sequencer for the 32-point MDC FFT: gates the pipeline enable, drives commutator/ROM codes,
// flushes PIPE_LAT cycles after the last input and flags valid outputs one cycle after each ce.
module fft_mdc_ctrl
  import fft_mdc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fft_mdc_ctrl_if.slave      bus
);
  state_e state_q, state_d;

  logic              ce, in_ready, clr, fill_en, flush_en;
  logic              err_q, err_d, ov_q, ov_d, ol_q, ol_d;
  logic [CNT_W-1:0]  sc;
  logic [FILL_W-1:0] fill, flush_cnt;
  logic              fill_full, flush_done, misaligned;

  assign fill_full  = (fill == FILL_W'(PIPE_LAT));
  assign flush_done = (flush_cnt == FILL_W'(PIPE_LAT - 1));
  assign misaligned = (sc[FRM_W-1:0] != FRM_W'(FRAME_CYC - 1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    ce       = 1'b0;
    clr      = 1'b0;
    fill_en  = 1'b0;
    flush_en = 1'b0;
    err_d    = err_q;
    ov_d     = 1'b0;
    ol_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        ce       = bus.in_valid;
        fill_en  = bus.in_valid;
        // Once the pipe is full, every accepted sample pushes one result out.
        ov_d     = bus.in_valid & fill_full;
        if (bus.in_valid && bus.in_last) begin
          state_d = ST_FLUSH;
          if (misaligned) err_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        ce       = 1'b1;
        flush_en = 1'b1;
        ov_d     = 1'b1;
        if (flush_done) begin
          state_d = ST_IDLE;
          ol_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

  fft_ctrl_cnt #(.W(CNT_W), .MAX((1 << CNT_W) - 1), .SAT(1'b0)) u_state_code (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(ce), .cnt_o(sc)
  );

  fft_ctrl_cnt #(.W(FILL_W), .MAX(PIPE_LAT), .SAT(1'b1)) u_fill (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(fill_en), .cnt_o(fill)
  );

  fft_ctrl_cnt #(.W(FILL_W), .MAX(PIPE_LAT - 1), .SAT(1'b0)) u_flush (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(flush_en), .cnt_o(flush_cnt)
  );

  // ROM offsets are applied modulo the ROM depth, so only the low bits take part.
  assign bus.rom_16_counter = sc[3:0];
  assign bus.rom_8_counter  = sc[2:0] - 3'(ST2_OFF);
  assign bus.rom_4_counter  = sc[1:0] - 2'(ST3_OFF);

  assign bus.state_code = sc;
  assign bus.in_ready   = in_ready;
  assign bus.ce         = ce;
  assign bus.out_valid  = ov_q;
  assign bus.out_last   = ol_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_fft_mdc_ctrl.sv
// Randomised stream bench for fft_mdc_ctrl with a cycle-level behavioural model and literal pins.
module tb_fft_mdc_ctrl;
  import fft_mdc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  fft_mdc_ctrl_if bus();

  fft_mdc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: phase 0 idle / 1 accepting / 2 draining, code value, ce count since start,
  // drain cycles left, and the expected registered outputs for the current cycle.
  int m_mode, m_sc, m_k, m_left;
  bit m_err, m_ov, m_ol, m_known;

  int t_ce, t_ov, t_ol, t_first_ov, first_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step_model();
    bit e_ce, e_rdy, n_ov, n_ol;
    int modn;
    modn  = 1 << CNT_W;
    e_rdy = (m_mode == 1);
    e_ce  = (m_mode == 1) ? (bus.in_valid === 1'b1) : (m_mode == 2);
    if (m_known) begin
      chk("in_ready",   bus.in_ready,       e_rdy);
      chk("ce",         bus.ce,             e_ce);
      chk("state_code", bus.state_code,     m_sc);
      chk("rom16",      bus.rom_16_counter, m_sc % 16);
      chk("rom8",       bus.rom_8_counter,  (m_sc + modn - ST2_OFF) % 8);
      chk("rom4",       bus.rom_4_counter,  (m_sc + modn - ST3_OFF) % 4);
      chk("out_valid",  bus.out_valid,      m_ov);
      chk("out_last",   bus.out_last,       m_ol);
      chk("busy",       bus.busy,           m_mode != 0);
      chk("err",        bus.err,            m_err);
      if (bus.state_code === 6'd16) chk("rom8_at_16", bus.rom_8_counter, 0);
      if (bus.state_code === 6'd24) chk("rom4_at_24", bus.rom_4_counter, 0);
    end
    if (bus.ce === 1'b1) t_ce++;
    if (bus.out_valid === 1'b1) begin
      if (t_ov == 0) t_first_ov = cyc;
      t_ov++;
    end
    if (bus.out_last === 1'b1) t_ol++;

    if (rst) begin
      m_mode = 0; m_sc = 0; m_k = 0; m_left = 0;
      m_err = 0; m_ov = 0; m_ol = 0; m_known = 1;
    end else begin
      n_ov = e_ce && (m_k >= PIPE_LAT || m_mode == 2);
      n_ol = (m_mode == 2) && (m_left == 1);
      case (m_mode)
        0: if (bus.start) begin m_mode = 1; m_sc = 0; m_k = 0; m_err = 0; end
        1: if (bus.in_valid && bus.in_last) begin
             if (m_sc % FRAME_CYC != FRAME_CYC - 1) m_err = 1;
             m_mode = 2;
             m_left = PIPE_LAT;
           end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
      if (e_ce) begin
        m_sc = (m_sc + 1) % modn;
        m_k++;
      end
      m_ov = n_ov;
      m_ol = n_ol;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic stream(input int n, input int gap_pct, input int drop_lo, input int drop_hi,
                        input bit noise, input int rst_at, output logic err_at_start);
    int acc, rc;
    bit v;
    acc = 0; rc = 0;
    t_ce = 0; t_ov = 0; t_ol = 0; t_first_ov = -1; first_acc = -1;
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tick();
    err_at_start = bus.err;
    while (acc < n && rc < 2000) begin
      rc++;
      v = ($urandom_range(99) >= gap_pct) && !(rc >= drop_lo && rc <= drop_hi);
      bus.in_valid = v;
      bus.in_last  = v ? (acc == n - 1) : (noise && $urandom_range(3) == 0);
      bus.start    = noise && $urandom_range(7) == 0;
      if (v) begin
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end
      tick();
    end
    chk("accept_budget", acc, n);
    for (int i = 0; i < 200; i++) begin
      if (bus.busy !== 1'b1) break;
      bus.in_valid = noise && $urandom_range(1) == 1;
      bus.in_last  = noise && $urandom_range(1) == 1;
      bus.start    = noise && $urandom_range(3) == 0;
      if (rst_at > 0 && i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy",      bus.busy,       0);
        chk("rst_out_valid", bus.out_valid,  0);
        chk("rst_out_last",  bus.out_last,   0);
        chk("rst_code",      bus.state_code, 0);
      end else begin
        tick();
      end
    end
    chk("drain_budget", bus.busy, 0);
    bus.start = 1'b0; bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = $urandom_range(1) == 1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic e0;
    int n, exp_ov;
    m_known = 0; m_mode = 0; m_sc = 0; m_k = 0; m_left = 0;
    m_err = 0; m_ov = 0; m_ol = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy",      bus.busy,       0);
    chk("reset_code",      bus.state_code, 0);
    chk("reset_out_valid", bus.out_valid,  0);
    chk("reset_err",       bus.err,        0);
    chk("idle_ce",         bus.ce,         0);
    chk("idle_in_ready",   bus.in_ready,   0);
    bus.in_valid = 1'b0;

    // One aligned frame, no gaps
    stream(32, 0, 0, -1, 1'b0, 0, e0);
    chk("t1_ce_cycles",   t_ce, 63);
    chk("t1_out_valid",   t_ov, 32);
    chk("t1_first_delay", t_first_ov - first_acc, 32);
    chk("t1_out_last",    t_ol, 1);
    chk("t1_err",         bus.err, 0);

    // Stall window on run cycles 5..9
    stream(32, 0, 5, 9, 1'b0, 0, e0);
    chk("t2_out_valid", t_ov, 32);
    chk("t2_ce_cycles", t_ce, 63);
    chk("t2_out_last",  t_ol, 1);

    // Two frames: code wraps, ends at (64+31) mod 64
    stream(64, 0, 0, -1, 1'b0, 0, e0);
    chk("t3_out_valid", t_ov, 64);
    chk("t3_out_last",  t_ol, 1);
    chk("t3_err",       bus.err, 0);
    chk("t3_final_code", bus.state_code, 31);

    // Misaligned last at accepted cycle 20
    stream(20, 0, 0, -1, 1'b0, 0, e0);
    chk("t4_err",       bus.err, 1);
    chk("t4_flush_ce",  t_ce - 20, 31);
    chk("t4_out_valid", t_ov, 31);
    chk("t4_out_last",  t_ol, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_err_sticky", bus.err, 1);

    // Noisy stream with start during run, reset mid-flush
    stream(32, 20, 0, -1, 1'b1, 10, e0);
    chk("t5_err_cleared", e0, 0);
    chk("t5_no_out_last", t_ol, 0);
    chk("t5_idle",        bus.busy, 0);

    for (int r = 0; r < 8; r++) begin
      n = ($urandom_range(3) == 0) ? $urandom_range(1, 96) : 32 * $urandom_range(1, 3);
      stream(n, $urandom_range(60), 0, -1, 1'b1, 0, e0);
      exp_ov = (n >= PIPE_LAT) ? n : PIPE_LAT;
      chk("rand_out_valid", t_ov, exp_ov);
      chk("rand_out_last",  t_ol, 1);
      chk("rand_ce",        t_ce, n + PIPE_LAT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
